alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_addsub.sv | 21 ++
 rtl/alu.sv | 50 +++++
 tb/tb_alu.sv | 117 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and condition-flag bit positions shared by the ALU
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam int ZF_BIT = 0;
    localparam int SF_BIT = 1;
    localparam int OF_BIT = 2;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: WIDTH-bit adder/subtractor returning the sum and signed overflow
module alu_addsub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] bx;

    // subtraction as a + ~b + 1; overflow when both addends agree in sign but the sum does not
    always_comb begin
        bx  = sub ? ~b : b;
        sum = a + bx + WIDTH'(sub);
        ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// alu: registered ADD/SUB/AND/XOR with zero, sign and overflow flags
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       cf
);

    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [WIDTH-1:0] res;
    logic [2:0]       flags;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (a),
        .b   (b),
        .sub (control == ALU_SUB),
        .sum (sum),
        .ovf (ovf)
    );

    // result select and flags; overflow only has meaning for the arithmetic ops
    always_comb begin
        res = control == ALU_AND ? a & b :
              control == ALU_XOR ? a ^ b : sum;
        flags         = '0;
        flags[ZF_BIT] = res == '0;
        flags[SF_BIT] = res[WIDTH-1];
        flags[OF_BIT] = control[1] ? 1'b0 : ovf;
    end

    // result and flags captured together so they always describe the same operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            cf  <= '0;
        end else begin
            out <= res;
            cf  <= flags;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed checks of alu against a signed-arithmetic reference
module tb_alu;

    localparam int W = 64;
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAXN = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   control = 2'b00;
    logic [W-1:0] out;
    logic [2:0]   cf;

    int errors = 0;
    int checks = 0;

    alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .control (control),
        .out     (out),
        .cf      (cf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference: exact signed result, then wrap; overflow when the exact value does not fit
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op);
        logic signed [W:0] ex;
        logic [W-1:0]      r;
        logic              of;
        ex = '0;
        of = 1'b0;
        case (op)
            2'b00: begin ex = $signed({x[W-1], x}) + $signed({y[W-1], y}); r = ex[W-1:0]; of = ex[W] != ex[W-1]; end
            2'b01: begin ex = $signed({x[W-1], x}) - $signed({y[W-1], y}); r = ex[W-1:0]; of = ex[W] != ex[W-1]; end
            2'b10: r = x & y;
            default: r = x ^ y;
        endcase
        return {of, r[W-1], r == '0, r};
    endfunction

    task automatic step(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op);
        logic [W+2:0] e;
        @(negedge clk);
        a = x;
        b = y;
        control = op;
        e = model(x, y, op);
        @(posedge clk);
        #1;
        check("out", out, e[W-1:0]);
        check("cf", W'(cf), W'(e[W+2:W]));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] s [6];
        s = '{MAXP, MAXN, '0, '1, W'(1), MAXN + W'(1)};
        return ($urandom_range(0, 3) == 0) ? s[$urandom_range(0, 5)] : {$urandom, $urandom};
    endfunction

    initial begin
        #2;
        check("rst_out", out, '0);
        check("rst_cf", W'(cf), '0);
        @(negedge clk);
        rst_n = 1'b1;

        step(W'(11), W'(4), 2'b00); check("d032_add", out, W'(15)); check("d032_add_cf", W'(cf), W'(3'b000));
        step(W'(11), W'(4), 2'b01); check("d032_sub", out, W'(7));  check("d032_sub_cf", W'(cf), W'(3'b000));
        step(W'(11), W'(4), 2'b10); check("d032_and", out, W'(0));  check("d032_and_cf", W'(cf), W'(3'b001));
        step(W'(11), W'(4), 2'b11); check("d032_xor", out, W'(15)); check("d032_xor_cf", W'(cf), W'(3'b000));
        step(-W'(11), W'(4), 2'b00); check("d033_add", out, -W'(7));  check("d033_add_cf", W'(cf), W'(3'b010));
        step(-W'(11), W'(4), 2'b01); check("d033_sub", out, -W'(15)); check("d033_sub_cf", W'(cf), W'(3'b010));
        step(MAXP, W'(1), 2'b00); check("d034_add", out, MAXN); check("d034_add_cf", W'(cf), W'(3'b110));
        step(MAXP, -W'(4), 2'b01); check("d034_sub", out, MAXN + W'(3)); check("d034_sub_cf", W'(cf), W'(3'b110));
        step(MAXN, W'(1), 2'b01); check("d035_sub", out, MAXP); check("d035_sub_cf", W'(cf), W'(3'b100));
        step(W'(5), W'(5), 2'b11); check("d035_xor", out, '0); check("d035_xor_cf", W'(cf), W'(3'b001));
        step('0, '0, 2'b01); check("zero_sub", out, '0); check("zero_sub_cf", W'(cf), W'(3'b001));
        step(MAXN, MAXN, 2'b01); check("minneg_sub", out, '0); check("minneg_sub_cf", W'(cf), W'(3'b001));

        for (int i = 0; i < 300; i++) step(pick(), pick(), 2'($urandom_range(0, 3)));

        step(W'(11), W'(4), 2'b00);
        check("pre_rst", out, W'(15));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out, '0);
        check("async_rst_cf", W'(cf), '0);
        @(posedge clk);
        #1;
        check("held_rst_out", out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("released_out", out, '0);
        step(W'(2), W'(3), 2'b00);
        check("post_rst", out, W'(5));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
